// File: rtl/fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, buffers {pc, instr} pairs in a FIFO toward decode.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path from imem to decode on an empty queue.
module fetch_queue #(
    parameter int unsigned    DW       = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    CNTW     = $clog2(DEPTH) + 1,
    parameter logic [DW-1:0]  RESET_PC = '0,
    parameter int unsigned    ADDENT   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [DW-1:0]   imem_addr_o,
    input  logic [DW-1:0]   imem_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [DW-1:0]   instr_o,
    output logic [DW-1:0]   pc_o,
    output logic [DW-1:0]   pc_plus_4_o,
    input  logic            redirect_i,
    input  logic [DW-1:0]   redirect_pc_i,
    output logic [CNTW-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0]   fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CNTW-1:0] count;
    logic [DW-1:0]   mem_instr [DEPTH];
    logic [DW-1:0]   mem_pc    [DEPTH];

    logic empty;
    logic bypass;
    logic bypass_take;
    logic pop;
    logic push;
    logic wr_en;
    logic rd_en;

    assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & ~redirect_i & ~rst_i;
`else
    assign bypass = 1'b0;
`endif

    // Head selection: FIFO entry, zeros when empty, or the live imem word when bypassing
    always_comb begin
        instr_valid_o = ~empty;
        instr_o       = empty ? '0 : mem_instr[rd_ptr];
        pc_o          = empty ? '0 : mem_pc[rd_ptr];
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_data_i;
            pc_o          = fetch_pc;
        end
    end

    assign pc_plus_4_o = pc_o + DW'(ADDENT);
    assign imem_addr_o = fetch_pc;
    assign count_o     = count;

    assign pop         = instr_valid_o & instr_ready_i;
    assign push        = ~redirect_i & ((count < CNTW'(DEPTH)) | pop);
    // A bypassed word consumed directly by decode never touches the FIFO
    assign bypass_take = bypass & instr_ready_i;
    assign wr_en       = push & ~bypass_take;
    assign rd_en       = pop & ~bypass_take & ~redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[DW-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) fetch_pc <= fetch_pc + DW'(ADDENT);
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_instr[wr_ptr] <= imem_data_i;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; imem returns addr ^ 32'hA5A5_0000.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus_4_o   (pc_plus_4),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .count_o       (count)
    );

    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

`ifndef FETCH_QUEUE_BYPASS_EN
    task automatic test_reset();
        do_reset();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
        checks++; if (pc_plus_4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h exp 4", pc_plus_4); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, instr_valid); end
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, pc, 32'(4 * i)); end
            checks++; if (instr !== (32'(4 * i) ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_instr[%0d]: got %h exp %h", i, instr, 32'(4 * i) ^ 32'hA5A5_0000); end
            checks++; if (pc_plus_4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_pc4[%0d]: got %h exp %h", i, pc_plus_4, 32'(4 * i + 4)); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d exp 1", i, count); end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall_and_full_pop();
        int n;
        do_reset();
        instr_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            n = (i < 4) ? i : 4;
            checks++; if (count !== 3'(n)) begin errors++; $display("FAIL stall_count[%0d]: got %0d exp %0d", i, count, n); end
            checks++; if (imem_addr !== 32'(4 * n)) begin errors++; $display("FAIL stall_addr[%0d]: got %h exp %h", i, imem_addr, 32'(4 * n)); end
            checks++; if (pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d]: got %h exp 0", i, pc); end
        end
        // full queue: one cycle pops 0x0 and pushes 0x10
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pop_count: got %0d exp 4", count); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL full_pop_head: got %h exp 4", pc); end
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL full_pop_addr: got %h exp 14", imem_addr); end
        step();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL full_hold_head: got %h exp 4", pc); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (pc !== 32'(8 + 4 * k)) begin errors++; $display("FAIL full_drain_pc[%0d]: got %h exp %h", k, pc, 32'(8 + 4 * k)); end
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_drain_count[%0d]: got %0d exp 4", k, count); end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        instr_ready = 1'b0;
        step(); step(); step();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d exp 3", count); end
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        instr_ready = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", instr_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_count: got %0d exp 0", count); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h exp 100", imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid: got %b exp 1", instr_valid); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc: got %h exp 100", pc); end
        checks++; if (instr !== 32'hA5A5_0100) begin errors++; $display("FAIL redir_first_instr: got %h exp a5a50100", instr); end
        checks++; if (pc_plus_4 !== 32'h104) begin errors++; $display("FAIL redir_first_pc4: got %h exp 104", pc_plus_4); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL redir_first_count: got %0d exp 1", count); end
    endtask

    task automatic test_reset_dominates();
        do_reset();
        instr_ready = 1'b0;
        step(); step(); step();
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        step();
        rst         = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstdom_valid: got %b exp 0", instr_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstdom_count: got %0d exp 0", count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rstdom_addr: got %h exp 0", imem_addr); end
        checks++; if (pc_plus_4 !== 32'h4) begin errors++; $display("FAIL rstdom_pc4: got %h exp 4", pc_plus_4); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rstdom_restart_pc: got %h exp 0", pc); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rstdom_restart_addr: got %h exp 4", imem_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        step();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h exp fffffffc", pc); end
        checks++; if (pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h exp 0", pc_plus_4); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h exp 0", pc); end
        instr_ready = 1'b0;
    endtask
`else
    task automatic test_bypass();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL byp_valid[%0d]: got %b exp 1", i, instr_valid); end
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL byp_pc[%0d]: got %h exp %h", i, pc, 32'(4 * i)); end
            checks++; if (instr !== (32'(4 * i) ^ 32'hA5A5_0000)) begin errors++; $display("FAIL byp_instr[%0d]: got %h exp %h", i, instr, 32'(4 * i) ^ 32'hA5A5_0000); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count[%0d]: got %0d exp 0", i, count); end
            step();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_bypass_stall();
        do_reset();
        instr_ready = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL byps_pc0: got %h exp 0", pc); end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (count !== 3'((i < 4) ? i : 4)) begin errors++; $display("FAIL byps_count[%0d]: got %0d", i, count); end
            checks++; if (pc !== 32'h0) begin errors++; $display("FAIL byps_head[%0d]: got %h exp 0", i, pc); end
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
`ifndef FETCH_QUEUE_BYPASS_EN
        test_reset();
        test_stream();
        test_stall_and_full_pop();
        test_redirect();
        test_reset_dominates();
        test_pc_wrap();
`else
        test_bypass();
        test_bypass_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised decoupled fetch stage for the pipelined RISC-V core; replaces the bare PC register plus the fixed IF/ID pipeline register.
- Owns the fetch PC and drives the combinational instruction memory address.
- Buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all buffered entries and restarts fetch at a new PC.

Parameters:
- DW, 32, data/address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNTW, $clog2(DEPTH)+1, occupancy counter width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- ADDENT, 4, PC increment per fetch.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- imem_addr_o  out  DW  instruction memory address (= fetch PC).
- imem_data_i  in  DW  instruction word; combinational from imem_addr_o, same cycle.
- instr_valid_o  out  1  head entry valid toward decode.
- instr_ready_i  in  1  decode accepts head entry this cycle.
- instr_o  out  DW  head instruction.
- pc_o  out  DW  PC of head instruction.
- pc_plus_4_o  out  DW  pc_o + ADDENT.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  DW  restart PC; bits [1:0] forced to 0.
- count_o  out  CNTW  current FIFO occupancy.

Behaviour:
- Reset (sync, rst_i high at edge):
  - fetch_pc = RESET_PC; rd_ptr = wr_ptr = 0; count = 0.
  - Outputs: instr_valid_o = 0, instr_o = 0, pc_o = 0, pc_plus_4_o = ADDENT, count_o = 0, imem_addr_o = RESET_PC.
  - Reset dominates redirect and any handshake in the same cycle.
- pop = instr_valid_o & instr_ready_i.
- push = !redirect_i & (count < DEPTH | pop).
  - Full FIFO with a simultaneous pop still pushes.
  - Push writes {fetch_pc, imem_data_i} at wr_ptr; then wr_ptr += 1 (wraps mod DEPTH) and fetch_pc += ADDENT.
- Pop: rd_ptr += 1 (wraps mod DEPTH).
- count update:
  - push & !pop: +1
  - pop & !push: -1
  - both or neither: unchanged
- count never exceeds DEPTH and never underflows.
- Head outputs: instr_o and pc_o are the entry at rd_ptr. instr_valid_o = (count != 0); instr_o = 0 and pc_o = 0 when count == 0.
- Latency: an instruction pushed at edge N is visible at the head in cycle N+1 when the FIFO was empty. First valid output is the cycle after reset deasserts.
- Redirect (redirect_i = 1 at edge):
  - rd_ptr = wr_ptr = 0; count = 0; fetch_pc = {redirect_pc_i[DW-1:2], 2'b00}.
  - No push and no pop take effect that cycle; a head entry presented with ready=1 is discarded, not consumed.
  - instr_valid_o = 0 in the cycle after the redirect; the first redirected instruction is valid one cycle later.
- Decode stall: instr_ready_i = 0 holds the head stable. Fetch continues until count == DEPTH, then fetch_pc and imem_addr_o hold.
- Handshake rule: while instr_valid_o = 1 and not yet accepted, instr_o and pc_o do not change, except on redirect or reset.
- fetch_pc wraps modulo 2^DW.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and redirect_i = 0, instr_valid_o = 1 and instr_o, pc_o, pc_plus_4_o show imem_data_i and fetch_pc combinationally.
  - If instr_ready_i = 1 that cycle, the word is consumed without being written to the FIFO: no count change, fetch_pc advances.
  - If instr_ready_i = 0, the word is pushed normally.
  - This gives zero-cycle fetch latency on an empty queue.
- Undefined: one-cycle FIFO latency as described above; no combinational path from imem_data_i to instr_o.

Test Plan:
- Reset, then ready = 1 held for 6 cycles, imem returns addr^32'hA5A5_0000 -> pc_o sequence 0x0, 0x4, 0x8, ... one per cycle starting the cycle after reset deasserts; count_o stays 1.
- ready = 0 for 8 cycles after reset -> count_o climbs 1, 2, 3, 4 then holds; imem_addr_o holds at 0x10; head stays pc_o = 0x0.
- FIFO full (count 4), ready = 1 for one cycle -> pop pc 0x0 and push pc 0x10 in the same cycle; count_o stays 4; next head pc_o = 0x4.
- Redirect to 0x103 with count 3 and ready = 1 in the same cycle -> no pop; next cycle instr_valid_o = 0 and count_o = 0; following cycle pc_o = 0x100.
- rst_i asserted while count = 3 and redirect_i = 1 -> all outputs at reset values; fetch restarts at RESET_PC, not at redirect_pc_i.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, ready = 1 -> instr_o equals imem_data_i in the same cycle, count_o stays 0, pc_o advances by 4 each cycle.
